// File: rtl/shift_cmd_sequencer.sv
// Sequences (mode, dir, data, serial-in, length) commands onto a 4-bit universal shift register.
// ENB rises the cycle after acceptance and holds for LEN edges; one-entry pending slot, READY low while it is full.
module shift_cmd_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_MODO,
  input  logic             CMD_DIR,
  input  logic [3:0]       CMD_D,
  input  logic             CMD_S_IN,
  input  logic [CNT_W-1:0] CMD_LEN,
  input  logic             ABORT,
  output logic [1:0]       MODO,
  output logic             DIR,
  output logic [3:0]       D,
  output logic             S_IN,
  output logic             ENB,
  output logic             BUSY,
  output logic             DONE,
  output logic [7:0]       CMD_COUNT
);

  typedef struct packed {
    logic [1:0] modo;
    logic       dir;
    logic [3:0] d;
    logic       s_in;
  } cmd_t;

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W:0] REM_LAST = (CNT_W+1)'(1);

  state_t           state;
  logic [CNT_W:0]   remaining;
  cmd_t             act_cmd;
  cmd_t             pend_cmd;
  logic [CNT_W-1:0] pend_len;
  logic             pend_vld;
  logic             done_q;
  logic [7:0]       cmd_count;
  cmd_t             cmd_in;
  logic             accept;

  // A zero length field means the full 2^CNT_W cycles.
  function automatic logic [CNT_W:0] len_cycles(input logic [CNT_W-1:0] len);
    logic [CNT_W:0] r;
    r = {1'b0, len};
    if (len == '0) r[CNT_W] = 1'b1;
    return r;
  endfunction

  assign cmd_in    = {CMD_MODO, CMD_DIR, CMD_D, CMD_S_IN};
  assign CMD_READY = ~pend_vld & ~RESET;
  assign accept    = CMD_VALID & CMD_READY & ~ABORT;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      remaining <= '0;
      act_cmd   <= '0;
      pend_cmd  <= '0;
      pend_len  <= '0;
      pend_vld  <= 1'b0;
      done_q    <= 1'b0;
      cmd_count <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) cmd_count <= cmd_count + 8'd1;
      if (ABORT) begin
        state     <= IDLE;
        remaining <= '0;
        act_cmd   <= '0;
        pend_vld  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              act_cmd   <= cmd_in;
              remaining <= len_cycles(CMD_LEN);
              state     <= RUN;
            end
          end
          RUN: begin
            if (remaining == REM_LAST) begin
              done_q <= 1'b1;
              // Pending wins; READY is low whenever the slot is full, so accept cannot collide with it.
              if (pend_vld) begin
                act_cmd   <= pend_cmd;
                remaining <= len_cycles(pend_len);
                pend_vld  <= 1'b0;
              end else if (accept) begin
                act_cmd   <= cmd_in;
                remaining <= len_cycles(CMD_LEN);
              end else begin
                act_cmd   <= '0;
                remaining <= '0;
                state     <= IDLE;
              end
            end else begin
              remaining <= remaining - REM_LAST;
              if (accept) begin
                pend_cmd <= cmd_in;
                pend_len <= CMD_LEN;
                pend_vld <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign MODO      = act_cmd.modo;
  assign DIR       = act_cmd.dir;
  assign D         = act_cmd.d;
  assign S_IN      = act_cmd.s_in;
  assign ENB       = (state == RUN);
  assign BUSY      = (state == RUN);
  assign DONE      = done_q;
  assign CMD_COUNT = cmd_count;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed bench for shift_cmd_sequencer with a behavioural model of the downstream shift register.
module tb_shift_cmd_sequencer;

  localparam logic [1:0] L = 2'b01;
  localparam logic [1:0] P = 2'b10;
  localparam logic [1:0] C = 2'b11;

  logic       CLK, RESET, CMD_VALID, CMD_READY, CMD_DIR, CMD_S_IN, ABORT;
  logic [1:0] CMD_MODO, MODO;
  logic [3:0] CMD_D, CMD_LEN, D, q;
  logic       DIR, S_IN, ENB, BUSY, DONE;
  logic [7:0] CMD_COUNT;

  int total = 0;
  int bad   = 0;

  shift_cmd_sequencer #(.CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_MODO(CMD_MODO), .CMD_DIR(CMD_DIR), .CMD_D(CMD_D), .CMD_S_IN(CMD_S_IN),
    .CMD_LEN(CMD_LEN), .ABORT(ABORT), .MODO(MODO), .DIR(DIR), .D(D), .S_IN(S_IN),
    .ENB(ENB), .BUSY(BUSY), .DONE(DONE), .CMD_COUNT(CMD_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Downstream universal shift register model.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) q <= 4'b0000;
    else if (ENB) begin
      case (MODO)
        L: q <= D;
        P: q <= DIR ? {S_IN, q[3:1]} : {q[2:0], S_IN};
        C: q <= DIR ? {q[0], q[3:1]} : {q[2:0], q[3]};
        default: q <= q;
      endcase
    end
  end

  typedef struct {
    logic       vld;
    logic [1:0] modo;
    logic       dir;
    logic [3:0] d;
    logic       sin;
    logic [3:0] len;
    logic       ab;
    logic       e_enb;
    logic       e_done;
    logic       e_rdy;
    logic [1:0] e_modo;
    logic [3:0] e_d;
    logic [7:0] e_cnt;
    logic [3:0] e_q;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic step(input logic vld, input logic [1:0] modo, input logic dir, input logic [3:0] d,
                      input logic sin, input logic [3:0] len, input logic ab);
    CMD_VALID = vld; CMD_MODO = modo; CMD_DIR = dir; CMD_D = d;
    CMD_S_IN = sin; CMD_LEN = len; ABORT = ab;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int n_enb, n_done, rises;
    logic prev;

    vecs[0]  = '{1'b1, L, 1'b0, 4'b1101, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0, 1'b1, L,     4'b1101, 8'd1, 4'b0000};
    for (int i = 1; i <= 5; i++)
      vecs[i] = '{1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, L, 4'b1101, 8'd1, 4'b1101};
    vecs[6]  = '{1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 4'b0000, 8'd1, 4'b1101};
    vecs[7]  = '{1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 8'd1, 4'b1101};
    vecs[8]  = '{1'b1, L,     1'b0, 4'b1010, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, L,     4'b1010, 8'd2, 4'b1101};
    vecs[9]  = '{1'b1, C,     1'b0, 4'b0000, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, L,     4'b1010, 8'd3, 4'b1010};
    vecs[10] = '{1'b1, P,     1'b1, 4'b1111, 1'b1, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1, C,     4'b0000, 8'd3, 4'b1010};
    vecs[11] = '{1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, C,     4'b0000, 8'd3, 4'b0101};
    vecs[12] = '{1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, C,     4'b0000, 8'd3, 4'b1010};
    vecs[13] = '{1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 4'b0000, 8'd3, 4'b0101};
    vecs[14] = '{1'b1, L,     1'b0, 4'b0011, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, L,     4'b0011, 8'd4, 4'b0101};
    vecs[15] = '{1'b1, P,     1'b1, 4'b0000, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, L,     4'b0011, 8'd5, 4'b0011};
    vecs[16] = '{1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, L,     4'b0011, 8'd5, 4'b0011};
    vecs[17] = '{1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 8'd5, 4'b0011};
    vecs[18] = '{1'b1, L,     1'b0, 4'b1111, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 8'd5, 4'b0011};
    vecs[19] = '{1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 8'd5, 4'b0011};

    RESET = 1'b1; CMD_VALID = 1'b0; CMD_MODO = 2'b00; CMD_DIR = 1'b0;
    CMD_D = 4'b0000; CMD_S_IN = 1'b0; CMD_LEN = 4'd0; ABORT = 1'b0;
    #2;
    chk("reset_outs", 0, 32'({ENB, BUSY, DONE, MODO, DIR, D, S_IN, CMD_COUNT, CMD_READY}), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    chk("ready_after_reset", 0, 32'(CMD_READY), 32'd1);

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].vld, vecs[i].modo, vecs[i].dir, vecs[i].d, vecs[i].sin, vecs[i].len, vecs[i].ab);
      chk("enb",   i, 32'(ENB),       32'(vecs[i].e_enb));
      chk("busy",  i, 32'(BUSY),      32'(vecs[i].e_enb));
      chk("done",  i, 32'(DONE),      32'(vecs[i].e_done));
      chk("ready", i, 32'(CMD_READY), 32'(vecs[i].e_rdy));
      chk("modo",  i, 32'(MODO),      32'(vecs[i].e_modo));
      chk("d",     i, 32'(D),         32'(vecs[i].e_d));
      chk("count", i, 32'(CMD_COUNT), 32'(vecs[i].e_cnt));
      chk("q",     i, 32'(q),         32'(vecs[i].e_q));
    end

    // LEN=0 runs the full 16 cycles.
    step(1'b1, P, 1'b1, 4'b0000, 1'b1, 4'd0, 1'b0);
    chk("len0_fields", 0, 32'({MODO, DIR, S_IN}), 32'({P, 1'b1, 1'b1}));
    n_enb = 0; n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (ENB) n_enb++;
      if (DONE) n_done++;
      step(1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
    end
    chk("len0_enb_cycles", 0, 32'(n_enb), 32'd16);
    chk("len0_done", 0, 32'(n_done), 32'd1);
    chk("len0_q", 0, 32'(q), 32'b1111);
    chk("len0_count", 0, 32'(CMD_COUNT), 32'd6);

    // Asynchronous reset in the middle of a command.
    step(1'b1, L, 1'b1, 4'b1001, 1'b1, 4'd5, 1'b0);
    step(1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
    #2;
    RESET = 1'b1;
    #1;
    chk("midreset_outs", 0, 32'({ENB, BUSY, DONE, MODO, DIR, D, S_IN, CMD_COUNT, CMD_READY}), 32'd0);
    @(posedge CLK);
    #3;
    RESET = 1'b0;
    #1;
    chk("midreset_ready", 0, 32'(CMD_READY), 32'd1);
    step(1'b1, L, 1'b0, 4'b0110, 1'b0, 4'd1, 1'b0);
    chk("post_reset_enb", 0, 32'({ENB, D, CMD_COUNT}), 32'({1'b1, 4'b0110, 8'd1}));
    step(1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
    chk("post_reset_end", 0, 32'({ENB, DONE}), 32'({1'b0, 1'b1}));
    step(1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
    chk("post_reset_done_clr", 0, 32'(DONE), 32'd0);

    // 257 back-to-back single-cycle commands through the bypass path.
    RESET = 1'b1;
    #1;
    RESET = 1'b0;
    n_enb = 0; n_done = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 262; i++) begin
      if (i < 257) step(1'b1, L, 1'b0, 4'(i), 1'b0, 4'd1, 1'b0);
      else         step(1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
      if (ENB) n_enb++;
      if (DONE) n_done++;
      if (ENB && !prev) rises++;
      prev = ENB;
      if (i == 255) chk("wrap_count_256", i, 32'(CMD_COUNT), 32'd0);
    end
    chk("b2b_enb_cycles", 0, 32'(n_enb), 32'd257);
    chk("b2b_done_pulses", 0, 32'(n_done), 32'd257);
    chk("b2b_enb_continuous", 0, 32'(rises), 32'd1);
    chk("b2b_count", 0, 32'(CMD_COUNT), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_cmd_sequencer.md
# shift_cmd_sequencer

Command sequencer that sits directly upstream of the 4-bit universal shift register and drives its MODO, DIR, D, S_IN and ENB inputs. It accepts (mode, direction, data, serial-in, length) commands over a valid/ready handshake and applies each command to the register for exactly LEN clock edges. A one-entry pending buffer lets a second command queue behind the active one, so consecutive operations run with no idle gap. Benches and higher-level control use it in place of hand-timed `repeat(n) @(posedge CLK)` stimulus.

## Interface
- CNT_W, 4, width of the command length field; LEN=0 encodes 2^CNT_W cycles.
- CLK  in  1  rising-edge clock, shared with the shift register.
- RESET  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  pending slot free; a command is accepted on a rising edge where CMD_VALID & CMD_READY.
- CMD_MODO  in  2  register mode: the `LOAD`, `PUSH` or `CYCLE` code from definitions.v.
- CMD_DIR  in  1  shift direction, 0 = left, 1 = right.
- CMD_D  in  4  parallel load data.
- CMD_S_IN  in  1  serial input bit.
- CMD_LEN  in  CNT_W  number of active register cycles.
- ABORT  in  1  synchronous abort: discards the active and pending commands.
- MODO  out  2  to register.
- DIR  out  1  to register.
- D  out  4  to register.
- S_IN  out  1  to register.
- ENB  out  1  to register; high only while a command is active.
- BUSY  out  1  active command present.
- DONE  out  1  one-cycle pulse after each command completes normally.
- CMD_COUNT  out  8  number of accepted commands, modulo 256.

## Operation
- State: IDLE / RUN, plus a remaining-cycle counter (CNT_W+1 bits) and a pending slot holding valid bit, MODO, DIR, D, S_IN and LEN.
- CMD_READY = ~pending_valid & ~RESET, combinational.
- Accept in IDLE: the command goes directly to active. State becomes RUN and remaining is loaded with LEN, or 2^CNT_W when LEN=0.
- Accept in RUN: the command is stored in the pending slot.
- Accept on the final active edge with the slot empty: the command bypasses the slot and becomes active directly.
- RUN outputs: ENB=1, and MODO/DIR/D/S_IN equal the active command's fields, held constant. remaining decrements on every edge.
- Final edge (remaining==1):
  - If pending is valid, it is promoted to active and the slot is freed.
  - Otherwise, if a bypass command is accepted, it becomes active.
  - Otherwise the block returns to IDLE.
  - In every case DONE=1 for the following cycle.
- IDLE outputs: ENB=0 and MODO, DIR, D, S_IN all 0. BUSY = (state==RUN).
- ABORT sampled high: next state is IDLE, the pending slot is cleared, ENB=0 from the next cycle and no DONE is generated. A command offered on the same edge is not accepted (ABORT forces internal accept low), and CMD_COUNT is not incremented.
- CMD_COUNT increments on each accepted handshake and wraps 255 -> 0.

## Timing
- Reset (asynchronous assert): state IDLE, pending cleared, remaining 0; MODO=0, DIR=0, D=0, S_IN=0, ENB=0, BUSY=0, DONE=0, CMD_COUNT=0, CMD_READY=0. CMD_READY rises combinationally once RESET deasserts.
- Reset mid-operation: all outputs drop to 0 immediately, without waiting for a clock edge. The active and pending commands are lost.
- Latency: a command accepted at edge k drives ENB=1 starting just after edge k. The register samples it at edges k+1 through k+LEN. ENB falls just after edge k+LEN, and DONE is high for the cycle between edges k+LEN and k+LEN+1.
- Back-to-back: with a pending command, ENB stays high continuously. The outputs switch to the new fields just after the final edge of the previous command.
- DONE never lasts more than one cycle per command. Back-to-back completions produce separate pulses.

## Test plan
- Reset, then LOAD D=1101 LEN=6 -> ENB high exactly 6 cycles with D=1101; BUSY matches ENB; one DONE pulse; register Q=1101; CMD_COUNT=1.
- LOAD D=1010 LEN=2 followed immediately by CYCLE DIR=0 LEN=3 (CMD_VALID held) -> CMD_READY low while the slot is full; ENB high 5 consecutive cycles; MODO switches after 2 cycles; two DONE pulses, 3 cycles apart; register Q=1010 -> 0101 -> 1010 -> 0101.
- PUSH DIR=1 S_IN=1 LEN=0 -> ENB high exactly 16 cycles; register Q=1111.
- LEN=5 command with a second command pending; ABORT asserted in the 3rd active cycle -> ENB=0 and BUSY=0 the next cycle; no DONE; pending discarded; CMD_READY=1.
- RESET asserted between edges mid-command -> all outputs 0 immediately; after release, a new LOAD LEN=1 gives ENB for 1 cycle and CMD_COUNT=1.
- 257 LEN=1 commands issued back-to-back -> CMD_COUNT=1 at the end; ENB high 257 continuous cycles; 257 DONE pulses.
